timer_bank: RTL and testbench
=============================

# timer_bank

Multi-channel programmable periodic/one-shot tick generator; the parametrised successor to the single fixed free-running timer. Each of NUM_CH channels holds its own period and mode, loaded through a simple write port, and emits a one-cycle `tick` at each terminal count. It drives periodic triggers (UART frame start, sampling strobes, counter resets) in the same clock domain, replacing hard-wired all-ones counter decodes.

## Interface
- NUM_CH, default 4: number of independent channels (1..16).
- CNT_W, default 8: width of period and counter per channel (2..32).
- CH_W, default 2: width of channel select; must satisfy 2^CH_W >= NUM_CH.

- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  configuration write strobe, one cycle.
- cfg_ch  in  CH_W  target channel; values >= NUM_CH are ignored (no effect).
- cfg_period  in  CNT_W  period value P; tick spacing is P+1 cycles.
- cfg_en  in  1  channel enable written with the config.
- cfg_oneshot  in  1  1 = one-shot, 0 = periodic.
- sync_clr  in  1  zero all channel counters simultaneously (phase alignment).
- tick  out  NUM_CH  registered one-cycle pulse per channel at terminal count.
- active  out  NUM_CH  registered per-channel enable state.
- tick_any  out  1  registered OR of all channel ticks, same cycle as `tick`.

## Operation
- Per channel i: registers period P[i], counter C[i], en[i], oneshot[i].
- Config write (cfg_we=1, cfg_ch=i valid): P[i]<=cfg_period, en[i]<=cfg_en, oneshot[i]<=cfg_oneshot, C[i]<=0, tick[i]<=0.
- Counting: while en[i]=1, at each edge: if C[i]==P[i] then C[i]<=0 and tick[i]<=1; else C[i]<=C[i]+1 and tick[i]<=0.
- Counter never exceeds P[i]; no wrap past 2^CNT_W-1 (P = all-ones gives period 2^CNT_W).
- P[i]=0: tick[i] held high every cycle while enabled in periodic mode.
- One-shot: on the edge that sets tick[i], en[i]<=0; C[i]<=0; channel stays idle until next config write.
- en[i]=0: C[i] holds 0, tick[i]=0.
- active = en registers directly.
- sync_clr=1: all C[i]<=0, tick<=0 on that edge; no channel ticks that edge; en/P unchanged.

## Timing
- Reset: C, P, en, oneshot, tick, active, tick_any all 0; channels idle.
- Config at edge k with en=1: C=0 after k; first tick high in the cycle after edge k+P+1 (latency P+1 edges); subsequent ticks every P+1 cycles.
- tick_any asserts in the same cycle as any tick bit (computed from next-state, registered together).
- Priority on one channel in one edge: rst > cfg write to that channel > sync_clr > count/terminal. A cfg write coinciding with terminal count suppresses that tick.
- sync_clr and cfg_we same edge: addressed channel takes config (C=0), others cleared; all restart aligned.
- Reset mid-count: outputs drop to 0 asynchronously; no tick after release until reconfigured.
- Writes to cfg_ch >= NUM_CH: no state changes anywhere.

## Test plan
- Reset then idle 50 cycles -> tick, active, tick_any all 0.
- Write ch0 P=3 periodic en=1 at edge k -> tick[0] high cycles after edges k+4, k+8, k+12; active[0]=1; tick_any mirrors.
- Write ch1 P=5 one-shot -> single tick[1] after edge k+6, active[1] falls at that same edge, no further ticks over 40 cycles.
- ch0 P=0 periodic -> tick[0] continuously high; ch2 P=255 (CNT_W=8) -> ticks exactly 256 cycles apart.
- ch0 P=3, ch1 P=7 running free; pulse sync_clr -> both restart, ch0 ticks at +4, ch1 at +8 after sync edge, tick_any high at +4 and +8 (coincident at +8).
- Rewrite ch0 on its terminal-count edge -> no tick that cycle, next tick P+1 edges after the write; assert rst mid-count -> all outputs 0 immediately.

Source files
------------

// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - multi-channel programmable periodic/one-shot tick generator
// Each channel counts 0..P and pulses tick for one cycle on the terminal count.
module timer_bank #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int CH_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic              cfg_en,
  input  logic              cfg_oneshot,
  input  logic              sync_clr,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] active,
  output logic              tick_any
);

  logic [NUM_CH-1:0][CNT_W-1:0] period_q, period_d;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]            en_q, en_d;
  logic [NUM_CH-1:0]            oneshot_q, oneshot_d;
  logic [NUM_CH-1:0]            tick_q, tick_d;
  logic                         tick_any_q;

  // Per-channel priority: config write > sync_clr > count/terminal.
  always_comb begin
    period_d  = period_q;
    cnt_d     = cnt_q;
    en_d      = en_q;
    oneshot_d = oneshot_q;
    tick_d    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_we && (cfg_ch == CH_W'(i))) begin
        period_d[i]  = cfg_period;
        en_d[i]      = cfg_en;
        oneshot_d[i] = cfg_oneshot;
        cnt_d[i]     = '0;
      end else if (sync_clr) begin
        cnt_d[i] = '0;
      end else if (en_q[i]) begin
        if (cnt_q[i] == period_q[i]) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b1;
          if (oneshot_q[i]) begin
            en_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q   <= '0;
      cnt_q      <= '0;
      en_q       <= '0;
      oneshot_q  <= '0;
      tick_q     <= '0;
      tick_any_q <= 1'b0;
    end else begin
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      oneshot_q  <= oneshot_d;
      tick_q     <= tick_d;
      tick_any_q <= |tick_d;
    end
  end

  assign tick     = tick_q;
  assign active   = en_q;
  assign tick_any = tick_any_q;

endmodule

// File: tb/tb_timer_bank.sv
// tb/tb_timer_bank.sv - directed and randomized checks of timer_bank against a countdown model
module tb_timer_bank;
  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_we = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_period = '0;
  logic              cfg_en = 1'b0;
  logic              cfg_oneshot = 1'b0;
  logic              sync_clr = 1'b0;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] active;
  logic              tick_any;

  int checks = 0;
  int errors = 0;

  timer_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_en(cfg_en), .cfg_oneshot(cfg_oneshot),
    .sync_clr(sync_clr), .tick(tick), .active(active), .tick_any(tick_any)
  );

  always #5 clk = ~clk;

  // Model: each channel counts down the edges left until its next tick.
  int m_p    [NUM_CH];
  int m_left [NUM_CH];
  bit m_en   [NUM_CH];
  bit m_os   [NUM_CH];
  bit m_tick [NUM_CH];

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_p[i] = 0; m_left[i] = 1; m_en[i] = 0; m_os[i] = 0; m_tick[i] = 0;
    end
  endfunction

  function automatic void model_edge();
    for (int i = 0; i < NUM_CH; i++) begin
      m_tick[i] = 0;
      if (cfg_we && int'(cfg_ch) == i) begin
        m_p[i] = int'(cfg_period); m_en[i] = cfg_en; m_os[i] = cfg_oneshot;
        m_left[i] = m_p[i] + 1;
      end else if (sync_clr) begin
        m_left[i] = m_p[i] + 1;
      end else if (m_en[i]) begin
        m_left[i] = m_left[i] - 1;
        if (m_left[i] == 0) begin
          m_tick[i] = 1;
          m_left[i] = m_p[i] + 1;
          if (m_os[i]) m_en[i] = 0;
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [NUM_CH-1:0] et, ea;
    for (int i = 0; i < NUM_CH; i++) begin
      et[i] = m_tick[i];
      ea[i] = m_en[i];
    end
    chk({tag, "_tick"}, 32'(tick), 32'(et));
    chk({tag, "_active"}, 32'(active), 32'(ea));
    chk({tag, "_tick_any"}, 32'(tick_any), 32'(|et));
  endtask

  task automatic step(input logic we, input int ch, input int per, input logic en,
                      input logic os, input logic sc, input string tag);
    int chv, pv;
    chv = ch; pv = per;
    cfg_we = we; cfg_ch = chv[CH_W-1:0]; cfg_period = pv[CNT_W-1:0];
    cfg_en = en; cfg_oneshot = os; sync_clr = sc;
    @(posedge clk);
    model_edge();
    #1;
    cfg_we = 1'b0; sync_clr = 1'b0;
    check_model(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    int t1, t2, w;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_model("reset");
    idle(50, "idle");

    // ch0 P=3 periodic: ticks after edges k+4, k+8, k+12
    step(1'b1, 0, 3, 1'b1, 1'b0, 1'b0, "cfg0");
    for (int n = 1; n <= 12; n++) begin
      step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, "per3");
      chk("per3_dir", 32'(tick[0]), 32'(n % 4 == 0));
      chk("per3_act", 32'(active[0]), 32'd1);
    end

    // ch1 P=5 one-shot: single tick after k+6, active falls same edge
    step(1'b1, 1, 5, 1'b1, 1'b1, 1'b0, "cfg1");
    for (int n = 1; n <= 40; n++) begin
      step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, "os5");
      chk("os5_tick", 32'(tick[1]), 32'(n == 6));
      chk("os5_act", 32'(active[1]), 32'(n < 6));
    end

    // ch0 P=0: tick held high
    step(1'b1, 0, 0, 1'b1, 1'b0, 1'b0, "cfg0p0");
    for (int n = 1; n <= 10; n++) begin
      step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, "p0");
      chk("p0_dir", 32'(tick[0]), 32'd1);
    end

    // ch2 P=255: ticks 256 cycles apart
    step(1'b1, 2, 255, 1'b1, 1'b0, 1'b0, "cfg2");
    t1 = -1; t2 = -1;
    for (int n = 1; n <= 600 && t2 < 0; n++) begin
      step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, "p255");
      if (tick[2]) begin
        if (t1 < 0) t1 = n; else t2 = n;
      end
    end
    chk("p255_first", 32'(t1), 32'd256);
    chk("p255_gap", 32'(t2 - t1), 32'd256);

    // ignored write to a nonexistent channel
    step(1'b1, 3, 1, 1'b1, 1'b0, 1'b0, "cfg_bad");

    // sync_clr alignment of ch0 P=3 and ch1 P=7
    step(1'b1, 2, 0, 1'b0, 1'b0, 1'b0, "dis2");
    step(1'b1, 0, 3, 1'b1, 1'b0, 1'b0, "cfgs0");
    step(1'b1, 1, 7, 1'b1, 1'b0, 1'b0, "cfgs1");
    idle($urandom_range(1, 20), "free");
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, "sync");
    chk("sync_edge", 32'(tick), 32'd0);
    for (int n = 1; n <= 8; n++) begin
      step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, "aligned");
      chk("sync_t0", 32'(tick[0]), 32'(n == 4 || n == 8));
      chk("sync_t1", 32'(tick[1]), 32'(n == 8));
      chk("sync_any", 32'(tick_any), 32'(n == 4 || n == 8));
    end

    // rewrite ch0 on its terminal-count edge suppresses the tick
    idle(3, "pre_term");
    step(1'b1, 0, 3, 1'b1, 1'b0, 1'b0, "cfg_term");
    chk("term_supp", 32'(tick[0]), 32'd0);
    for (int n = 1; n <= 4; n++) begin
      step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, "after_term");
      chk("term_next", 32'(tick[0]), 32'(n == 4));
    end

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      w = ($urandom_range(0, 7) == 0);
      step(1'(w), $urandom_range(0, 3),
           ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 12),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 31) == 0), "rand");
    end

    // asynchronous reset mid-count
    for (int i = 0; i < NUM_CH; i++) step(1'b1, i, 0, 1'b1, 1'b0, 1'b0, "cfg_pre_rst");
    idle(2, "pre_rst");
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_any", 32'(tick_any), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(20, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
